// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, counter debouncer and
// press/auto-repeat pulse generator for the game control inputs.
// level follows the debounced button; pulse is a one-cycle event on press
// and, for channels in REPEAT_MASK, on hold-to-repeat.
// state_dbg exposes each channel's pulse FSM state (2 bits per channel,
// channel i at [2*i +: 2]) so checkers can observe it without hierarchy.
module button_conditioner #(
  parameter int                NUM_CH          = 5,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter int                REPEAT_DELAY    = 20000000,
  parameter int                REPEAT_PERIOD   = 5000000,
  parameter logic [NUM_CH-1:0] REPEAT_MASK     = {NUM_CH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     btn_in,
  input  logic                  en,
  output logic [NUM_CH-1:0]     level,
  output logic [NUM_CH-1:0]     pulse,
  output logic [2*NUM_CH-1:0]   state_dbg
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  // WAIT: counting the initial repeat delay; REPEAT: held (periodic pulses
  // only on masked channels); BLOCKED: held but pulses forfeited by en=0.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_BLOCKED = 2'd3
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   d_q;
    logic [DW-1:0]          dcnt_q;
    logic                   accept;
    logic                   d_rise;
    logic                   d_fall;
    state_t                 state_q, state_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic                   pulse_q, pulse_d;

    // Synchroniser shift chain for the asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The new level is accepted on the edge where the disagreement has
    // persisted for DEBOUNCE_CYCLES samples; the FSM sees that same edge so
    // level and pulse rise together.
    assign accept = (s != d_q) && (dcnt_q == DC_LAST);
    assign d_rise = accept & s;
    assign d_fall = accept & ~s;

    // Debounce counter: any cycle where s agrees with d restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q    <= 1'b0;
        dcnt_q <= '0;
      end else if (s == d_q) begin
        dcnt_q <= '0;
      end else if (accept) begin
        d_q    <= s;
        dcnt_q <= '0;
      end else begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end

    // Pulse FSM state, repeat counter and registered pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        pulse_q <= pulse_d;
      end
    end

    // Next-state logic; a release overrides everything, including a
    // repeat pulse that falls due on the same edge.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      pulse_d = 1'b0;
      if (d_fall) begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (d_rise) begin
              rcnt_d = '0;
              if (en) begin
                pulse_d = 1'b1;
                state_d = REPEAT_MASK[i] ? ST_WAIT : ST_REPEAT;
              end else begin
                state_d = ST_BLOCKED;
              end
            end
          end
          ST_WAIT: begin
            if (!en) begin
              state_d = ST_BLOCKED;
              rcnt_d  = '0;
            end else if (rcnt_q == RD_LAST) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
              state_d = ST_REPEAT;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!en) begin
              state_d = ST_BLOCKED;
              rcnt_d  = '0;
            end else if (REPEAT_MASK[i]) begin
              if (rcnt_q == RP_LAST) begin
                pulse_d = 1'b1;
                rcnt_d  = '0;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
          end
          ST_BLOCKED: begin
            state_d = ST_BLOCKED;
          end
          default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    assign level[i]            = d_q;
    assign pulse[i]            = pulse_q;
    assign state_dbg[2*i +: 2] = state_q;
  end

endmodule
